// File: rtl/rtc_bus_scheduler.sv
// RTC bus scheduler: serialises write and poll-read requests onto a multiplexed address/data RTC bus.
// Optional macro RTC_SCHED_RR_EN selects round-robin arbitration instead of fixed write priority.
module rtc_bus_scheduler #(
  parameter int PHASE_CYC = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       wr_req_i,
  input  logic [7:0] wr_addr_i,
  input  logic [7:0] wr_data_i,
  input  logic       rd_req_i,
  input  logic [7:0] rd_addr_i,
  input  logic [7:0] bus_in_i,
  output logic       gnt_wr_o,
  output logic       gnt_rd_o,
  output logic       done_o,
  output logic       busy_o,
  output logic [7:0] rd_data_o,
  output logic       cs_n_o,
  output logic       ad_o,
  output logic       wr_n_o,
  output logic       rd_n_o,
  output logic [7:0] bus_out_o,
  output logic       bus_oe_o,
  output logic [2:0] state_o
);

  // Handshake: wr_req_i/rd_req_i are levels held by the requester until done_o;
  // a request is accepted only in an IDLE cycle with done_o low, and accepted
  // requests get exactly one gnt_* pulse and exactly one done_o pulse.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_A_STB = 3'd1;
  localparam logic [2:0] S_A_HLD = 3'd2;
  localparam logic [2:0] S_D_STB = 3'd3;
  localparam logic [2:0] S_D_HLD = 3'd4;

  localparam logic [3:0] LAST_CNT = 4'(PHASE_CYC - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       is_wr_q, is_wr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       gnt_wr_q, gnt_wr_d;
  logic       gnt_rd_q, gnt_rd_d;
  logic       done_q, done_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       cs_n_q, cs_n_d;
  logic       ad_q, ad_d;
  logic       wr_n_q, wr_n_d;
  logic       rd_n_q, rd_n_d;
  logic [7:0] bus_out_q, bus_out_d;
  logic       bus_oe_q, bus_oe_d;
  logic       pick_wr;

`ifdef RTC_SCHED_RR_EN
  logic ptr_wr_q, ptr_wr_d;
  // ptr_wr_q set means a write wins a tie
  assign pick_wr = wr_req_i && (!rd_req_i || ptr_wr_q);
`else
  assign pick_wr = wr_req_i;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    gnt_wr_d  = 1'b0;
    gnt_rd_d  = 1'b0;
    done_d    = 1'b0;
    rd_data_d = rd_data_q;
`ifdef RTC_SCHED_RR_EN
    ptr_wr_d  = ptr_wr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!done_q && (wr_req_i || rd_req_i)) begin
          state_d  = S_A_STB;
          cnt_d    = 4'd0;
          is_wr_d  = pick_wr;
          addr_d   = pick_wr ? wr_addr_i : rd_addr_i;
          data_d   = wr_data_i;
          gnt_wr_d = pick_wr;
          gnt_rd_d = !pick_wr;
`ifdef RTC_SCHED_RR_EN
          ptr_wr_d = !pick_wr;
`endif
        end
      end
      default: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = 4'd0;
          case (state_q)
            S_A_STB: state_d = S_A_HLD;
            S_A_HLD: state_d = S_D_STB;
            S_D_STB: state_d = S_D_HLD;
            default: begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          endcase
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    endcase
    // Poll value is taken on the last strobe cycle, when the RTC output is settled
    if (state_q == S_D_STB && cnt_q == LAST_CNT && !is_wr_q) begin
      rd_data_d = bus_in_i;
    end
  end

  // Strobes are decoded from the next state so they leave the flops glitch-free
  always_comb begin
    cs_n_d    = 1'b1;
    ad_d      = 1'b1;
    wr_n_d    = 1'b1;
    rd_n_d    = 1'b1;
    bus_oe_d  = 1'b0;
    bus_out_d = 8'h00;
    case (state_d)
      S_A_STB: begin
        cs_n_d    = 1'b0;
        ad_d      = 1'b0;
        wr_n_d    = 1'b0;
        bus_oe_d  = 1'b1;
        bus_out_d = addr_d;
      end
      S_A_HLD: begin
        bus_oe_d  = 1'b1;
        bus_out_d = addr_d;
      end
      S_D_STB: begin
        cs_n_d = 1'b0;
        if (is_wr_d) begin
          wr_n_d    = 1'b0;
          bus_oe_d  = 1'b1;
          bus_out_d = data_d;
        end else begin
          rd_n_d = 1'b0;
        end
      end
      S_D_HLD: begin
        if (is_wr_d) begin
          bus_oe_d  = 1'b1;
          bus_out_d = data_d;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      is_wr_q   <= 1'b0;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      gnt_wr_q  <= 1'b0;
      gnt_rd_q  <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= 8'h00;
      cs_n_q    <= 1'b1;
      ad_q      <= 1'b1;
      wr_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      bus_out_q <= 8'h00;
      bus_oe_q  <= 1'b0;
`ifdef RTC_SCHED_RR_EN
      ptr_wr_q  <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      gnt_wr_q  <= gnt_wr_d;
      gnt_rd_q  <= gnt_rd_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
      cs_n_q    <= cs_n_d;
      ad_q      <= ad_d;
      wr_n_q    <= wr_n_d;
      rd_n_q    <= rd_n_d;
      bus_out_q <= bus_out_d;
      bus_oe_q  <= bus_oe_d;
`ifdef RTC_SCHED_RR_EN
      ptr_wr_q  <= ptr_wr_d;
`endif
    end
  end

  assign gnt_wr_o  = gnt_wr_q;
  assign gnt_rd_o  = gnt_rd_q;
  assign done_o    = done_q;
  assign busy_o    = (state_q != S_IDLE);
  assign rd_data_o = rd_data_q;
  assign cs_n_o    = cs_n_q;
  assign ad_o      = ad_q;
  assign wr_n_o    = wr_n_q;
  assign rd_n_o    = rd_n_q;
  assign bus_out_o = bus_out_q;
  assign bus_oe_o  = bus_oe_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Bench for rtc_bus_scheduler: directed and randomized transactions checked against a
// cycle-offset reference model of the bus phases; a second instance covers PHASE_CYC=1.
module tb_rtc_bus_scheduler;
  localparam int P = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, wr_req, rd_req;
  logic [7:0] wr_addr, wr_data, rd_addr, bus_in;
  logic       gnt_wr, gnt_rd, done, busy, cs_n, ad, wr_n, rd_n, bus_oe;
  logic [7:0] rd_data, bus_out;
  logic [2:0] state;

  logic       s_reset, s_wr_req, s_rd_req;
  logic [7:0] s_wr_addr, s_wr_data, s_rd_addr, s_bus_in;
  logic       s_gnt_wr, s_gnt_rd, s_done, s_busy, s_cs_n, s_ad, s_wr_n, s_rd_n, s_bus_oe;
  logic [7:0] s_rd_data, s_bus_out;
  logic [2:0] s_state;

  rtc_bus_scheduler #(.PHASE_CYC(P)) dut (
    .clk_i(clk), .reset_i(reset), .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .bus_in_i(bus_in), .gnt_wr_o(gnt_wr), .gnt_rd_o(gnt_rd),
    .done_o(done), .busy_o(busy), .rd_data_o(rd_data), .cs_n_o(cs_n), .ad_o(ad), .wr_n_o(wr_n),
    .rd_n_o(rd_n), .bus_out_o(bus_out), .bus_oe_o(bus_oe), .state_o(state)
  );

  rtc_bus_scheduler #(.PHASE_CYC(1)) dut1 (
    .clk_i(clk), .reset_i(s_reset), .wr_req_i(s_wr_req), .wr_addr_i(s_wr_addr), .wr_data_i(s_wr_data),
    .rd_req_i(s_rd_req), .rd_addr_i(s_rd_addr), .bus_in_i(s_bus_in), .gnt_wr_o(s_gnt_wr),
    .gnt_rd_o(s_gnt_rd), .done_o(s_done), .busy_o(s_busy), .rd_data_o(s_rd_data), .cs_n_o(s_cs_n),
    .ad_o(s_ad), .wr_n_o(s_wr_n), .rd_n_o(s_rd_n), .bus_out_o(s_bus_out), .bus_oe_o(s_bus_oe),
    .state_o(s_state)
  );

  int         checks = 0;
  int         passed = 0;
  logic [7:0] exp_rd = 8'h00;
  bit         ptr_wr = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_gnt"}, {gnt_wr, gnt_rd}, 0);
    chk({tag, "_strobes"}, {cs_n, ad, wr_n, rd_n}, 4'hf);
    chk({tag, "_oe"}, bus_oe, 0);
    chk({tag, "_rd_data"}, rd_data, exp_rd);
  endtask

  function automatic logic [7:0] rnd8();
    return 8'($urandom_range(0, 255));
  endfunction

  // Entered in an arbitrating IDLE cycle with requests already driven; returns in the
  // cycle after done (or, when abort_k>0, in the cycle after the reset edge).
  task automatic do_txn(input int bus_val, input int abort_k);
    bit         w;
    int         ph;
    logic [7:0] a, d, cap;
    cap = 8'h00;
    @(negedge clk);
    check_idle("arb_idle");
`ifdef RTC_SCHED_RR_EN
    w = wr_req && (!rd_req || ptr_wr);
    ptr_wr = !w;
`else
    w = wr_req;
`endif
    a = w ? wr_addr : rd_addr;
    d = wr_data;
    for (int k = 1; k <= 4 * P + 1; k++) begin
      tick();
      bus_in = (bus_val < 0) ? rnd8() : 8'(bus_val);
      if (k == 3 * P) cap = bus_in;
      @(negedge clk);
      if (!w && k == 3 * P + 1) exp_rd = cap;
      ph = (k - 1) / P;
      chk("gnt_wr", gnt_wr, (k == 1) && w);
      chk("gnt_rd", gnt_rd, (k == 1) && !w);
      chk("done", done, k == 4 * P + 1);
      chk("busy", busy, k <= 4 * P);
      chk("cs_n", cs_n, !(ph == 0 || ph == 2));
      chk("ad", ad, ph != 0);
      chk("wr_n", wr_n, !(ph == 0 || (ph == 2 && w)));
      chk("rd_n", rd_n, !(ph == 2 && !w));
      chk("bus_oe", bus_oe, ph == 0 || ph == 1 || (w && (ph == 2 || ph == 3)));
      if (ph < 4 && (ph < 2 || w)) chk("bus_out", bus_out, (ph < 2) ? a : d);
      chk("rd_data", rd_data, exp_rd);
      if (k == abort_k) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_rd = 8'h00;
        ptr_wr = 1'b1;
        return;
      end
    end
    if (w) wr_req = 1'b0;
    else rd_req = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    reset = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = 8'h00; wr_data = 8'h00; rd_addr = 8'h00; bus_in = 8'h00;
    s_reset = 1'b1; s_wr_req = 1'b0; s_rd_req = 1'b0;
    s_wr_addr = 8'h00; s_wr_data = 8'h00; s_rd_addr = 8'h00; s_bus_in = 8'h00;
    repeat (2) tick();
    @(negedge clk);
    check_idle("reset");
    chk("reset_bus_out", bus_out, 8'h00);
    tick();
    reset = 1'b0;
    s_reset = 1'b0;

    // Directed write 0x21 <- 0x59
    wr_addr = 8'h21; wr_data = 8'h59; wr_req = 1'b1;
    do_txn(-1, 0);

    // Directed read of 0x22 returning 0x45
    rd_addr = 8'h22; rd_req = 1'b1;
    do_txn(8'h45, 0);
    chk("dir_rd_value", rd_data, 8'h45);

    // Random single transactions separated by random idle gaps
    for (int i = 0; i < 10; i++) begin
      wr_addr = rnd8(); wr_data = rnd8(); rd_addr = rnd8();
      if ($urandom_range(0, 1) == 1) wr_req = 1'b1;
      else rd_req = 1'b1;
      do_txn(-1, 0);
      n = $urandom_range(0, 3);
      for (int g = 0; g < n; g++) begin
        @(negedge clk);
        check_idle("gap_idle");
        tick();
      end
    end

    // Both requesters hold their requests continuously
    wr_req = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_txn(-1, 0);
      wr_addr = rnd8(); wr_data = rnd8(); rd_addr = rnd8();
      if (i < 3) begin
        wr_req = 1'b1; rd_req = 1'b1;
      end else begin
        wr_req = 1'b0; rd_req = 1'b0;
      end
    end
    @(negedge clk);
    check_idle("after_both");
    tick();

    // Reset in the first data-strobe cycle of a write, then the held request is regranted
    wr_addr = rnd8(); wr_data = rnd8(); wr_req = 1'b1;
    do_txn(-1, 2 * P + 1);
    do_txn(-1, 0);

    // PHASE_CYC=1 single read: done five cycles after the request cycle
    s_rd_addr = rnd8(); s_bus_in = 8'h5a; s_rd_req = 1'b1;
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      @(negedge clk);
      if (c == 1) chk("p1_gnt_rd", {s_gnt_wr, s_gnt_rd}, 2'b01);
      if (s_done) begin
        n = c;
        break;
      end
    end
    chk("p1_done_latency", n, 5);
    chk("p1_rd_data", s_rd_data, 8'h5a);
    s_rd_req = 1'b0;
    tick();
    @(negedge clk);
    chk("p1_idle_busy", s_busy, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rtc_bus_scheduler.md
RTC_BUS_SCHEDULER -- requirements
Module: rtc_bus_scheduler

Interface
REQ-001 Parameter PHASE_CYC, default 4: clock cycles per bus phase; legal range 1..15.
REQ-002 CLK  in  1  system clock; all logic on rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 wr_req  in  1  write request; level; held high by the requester until done.
REQ-005 wr_addr, wr_data  in  8 each  RTC register address and value to write.
REQ-006 rd_req  in  1  read (poll) request; level; held high by the requester until done.
REQ-007 rd_addr  in  8  RTC register address to read.
REQ-008 bus_in  in  8  sampled value of the shared address/data bus.
REQ-009 gnt_wr, gnt_rd  out  1 each  one-cycle grant pulse.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 busy  out  1  high in every state other than IDLE.
REQ-012 rd_data  out  8  last read value.
REQ-013 cs_n, ad, wr_n, rd_n  out  1 each  RTC bus strobes (ad=0 address phase, ad=1 data phase).
REQ-014 bus_out  out  8  bus drive value; bus_oe  out  1  tristate enable for bus_out.

Function
REQ-015 FSM states: IDLE, A_STB, A_HLD, D_STB, D_HLD; each non-IDLE state lasts exactly PHASE_CYC cycles, timed by a 4-bit phase counter.
REQ-016 IDLE: cs_n=1, ad=1, wr_n=1, rd_n=1, bus_oe=0.
REQ-017 A_STB: cs_n=0, ad=0, wr_n=0, bus_oe=1, bus_out=latched address.
REQ-018 A_HLD: cs_n=1, ad=1, wr_n=1, rd_n=1, bus_oe=1, bus_out=latched address.
REQ-019 D_STB write: cs_n=0, ad=1, wr_n=0, bus_oe=1, bus_out=latched data.
REQ-020 D_STB read: cs_n=0, ad=1, rd_n=0, bus_oe=0.
REQ-021 D_HLD: all strobes high; bus_oe=1 for write, 0 for read.
REQ-022 Read: bus_in is captured into rd_data on the last cycle of D_STB; rd_data holds until the next read completes.
REQ-023 Arbitration happens only in IDLE cycles with done=0; requests are ignored in all other cycles.
REQ-024 A request seen in IDLE at cycle t causes A_STB and a grant pulse at t+1, and latches the address/data at the t+1 edge.
REQ-025 On the final D_HLD cycle, the FSM returns to IDLE; done=1 in that first IDLE cycle, at t+1+4*PHASE_CYC.
REQ-026 Back-to-back transactions are separated by at least one IDLE cycle after the done cycle.
REQ-027 Exactly one of gnt_wr/gnt_rd pulses per transaction; done pulses exactly once per granted transaction.
REQ-028 Outputs are registered; no strobe glitches on state transitions.

Reset
REQ-029 While Reset=1 at a rising edge: state=IDLE, counter=0, gnt_*=0, done=0, busy=0, rd_data=0x00, bus_out=0x00, strobes at IDLE values, and the arbitration pointer selects write.
REQ-030 A reset during an active transaction aborts it at the next edge, with no done pulse; the requester keeps its request high to retry.

Configuration
REQ-031 Macro RTC_SCHED_RR_EN, when defined: round-robin arbitration; when both requests are pending, the type not granted last wins.
REQ-032 With RTC_SCHED_RR_EN defined, the pointer updates only on a grant.
REQ-033 Without the macro: fixed priority; a pending write always wins over a pending read.

Verification (PHASE_CYC=2)
REQ-034 Scenario: wr_req with addr 0x21, data 0x59 at t.
- gnt_wr at t+1.
- ad=0, wr_n=0, bus_out=0x21 at t+1..t+2.
- bus_out=0x59, wr_n=0 at t+5..t+6.
- done at t+9.
REQ-035 Scenario: rd_req with addr 0x22, bus_in=0x45 during D_STB.
- rd_n=0 at t+5..t+6 with bus_oe=0.
- rd_data=0x45 at done (t+9).
REQ-036 Scenario: wr_req and rd_req both asserted continuously, with the macro undefined.
- Every grant is gnt_wr.
REQ-037 Same stimulus as REQ-036 with RTC_SCHED_RR_EN defined.
- Grants alternate wr, rd, wr, rd, each pair separated by at least one non-done IDLE cycle.
REQ-038 Scenario: Reset=1 during D_STB of a write.
- Next cycle is IDLE, all strobes high, bus_oe=0, no done.
- A held wr_req is regranted after Reset falls.
REQ-039 Scenario: PHASE_CYC=1, single read.
- done exactly 5 cycles after the request cycle.
